pwm_capture_apb: RTL and testbench



---
 rtl/pwm_cap_pkg.sv | 22 ++
 rtl/pwm_capture_apb_if.sv | 22 ++
 rtl/sync_edge_det.sv | 31 +++
 rtl/pwm_capture_apb.sv | 161 ++++++++++++++++
 tb/tb_pwm_capture_apb.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_cap_pkg.sv
// Shared register map, STATUS bit positions and FSM state type for the PWM capture peripheral.
package pwm_cap_pkg;

  localparam logic [9:0] ADDR_CTRL   = 10'd0;
  localparam logic [9:0] ADDR_PERIOD = 10'd1;
  localparam logic [9:0] ADDR_HIGH   = 10'd2;
  localparam logic [9:0] ADDR_STATUS = 10'd3;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;

  localparam int STAT_VALID = 0;
  localparam int STAT_OVF   = 1;
  localparam int STAT_BUSY  = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } cap_state_t;

endpackage

// File: rtl/pwm_capture_apb_if.sv
// APB segment (10-bit word address, 16-bit data) between a bus master and the PWM capture slave.
interface pwm_capture_apb_if;

  logic [9:0]  paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [15:0] pwdata;
  logic [15:0] prdata;
  logic        pready;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready
  );

endinterface

// File: rtl/sync_edge_det.sv
// Synchronizes an asynchronous input through SYNC_STAGES flops and flags its rising/falling edges.
// rise/fall are single-cycle pulses derived from the synchronized level and one history register.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic in_sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign in_sync = sync_reg[SYNC_STAGES-1];
  assign rise    = in_sync & ~prev_reg;
  assign fall    = ~in_sync & prev_reg;

endmodule

// File: rtl/pwm_capture_apb.sv
// APB peripheral measuring period and high time of an external PWM signal in pclk cycles.
// Optional capture interrupt and CTRL.irq_en bit are built only when PWMCAP_IRQ_EN is defined.
module pwm_capture_apb
  import pwm_cap_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic                pclk,
  input  logic                preset,
  pwm_capture_apb_if.slave    apb,
  input  logic                pwm_in,
  output logic                irq
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             in_sync;
  logic             rise;
  logic             fall;
  logic             wr_en;
  logic             rd_en;
  logic             ctrl_wr;
  logic             stat_wr;
  logic             enable_reg;
  logic             enable_next;
  logic             capture;
  logic             overflow;
  cap_state_t       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] hi_tmp_reg;
  logic [CNT_W-1:0] period_reg;
  logic [CNT_W-1:0] high_reg;
  logic             valid_reg;
  logic             ovf_reg;
  logic [15:0]      rdata;

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge_det (
    .clk     (pclk),
    .rst_n   (preset),
    .din     (pwm_in),
    .in_sync (in_sync),
    .rise    (rise),
    .fall    (fall)
  );

  assign wr_en   = apb.psel & apb.penable & apb.pwrite;
  assign rd_en   = apb.psel & apb.penable & ~apb.pwrite;
  assign ctrl_wr = wr_en && (apb.paddr == ADDR_CTRL);
  assign stat_wr = wr_en && (apb.paddr == ADDR_STATUS);

  // The FSM looks at the enable value being written this cycle so a disable beats a same-cycle edge.
  assign enable_next = ctrl_wr ? apb.pwdata[CTRL_EN] : enable_reg;
  assign capture     = (state_reg == MEASURE) && enable_next && rise;
  assign overflow    = (state_reg == MEASURE) && enable_next && !rise && (cnt_reg == CNT_MAX);

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      enable_reg <= 1'b0;
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      hi_tmp_reg <= '0;
      period_reg <= '0;
      high_reg   <= '0;
      valid_reg  <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      enable_reg <= enable_next;
      // Hardware set takes priority over a same-cycle write-one-to-clear.
      valid_reg  <= capture  | (valid_reg & ~(stat_wr & apb.pwdata[STAT_VALID]));
      ovf_reg    <= overflow | (ovf_reg   & ~(stat_wr & apb.pwdata[STAT_OVF]));
      if (!enable_next) begin
        state_reg  <= IDLE;
        cnt_reg    <= '0;
        hi_tmp_reg <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            cnt_reg   <= '0;
            state_reg <= ARM;
          end
          ARM: begin
            if (rise) begin
              cnt_reg   <= CNT_ONE;
              state_reg <= MEASURE;
            end
          end
          MEASURE: begin
            if (rise) begin
              period_reg <= cnt_reg;
              high_reg   <= hi_tmp_reg;
              cnt_reg    <= CNT_ONE;
            end else if (cnt_reg == CNT_MAX) begin
              cnt_reg   <= '0;
              state_reg <= ARM;
            end else begin
              cnt_reg <= cnt_reg + CNT_ONE;
              if (fall) begin
                hi_tmp_reg <= cnt_reg;
              end
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

`ifdef PWMCAP_IRQ_EN
  logic irq_en_reg;
  logic irq_reg;

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      irq_en_reg <= 1'b0;
      irq_reg    <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        irq_en_reg <= apb.pwdata[CTRL_IRQ_EN];
      end
      irq_reg <= (valid_reg | ovf_reg) & irq_en_reg;
    end
  end

  assign irq = irq_reg;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    if (rd_en) begin
      case (apb.paddr)
        ADDR_CTRL: begin
          rdata[CTRL_EN] = enable_reg;
`ifdef PWMCAP_IRQ_EN
          rdata[CTRL_IRQ_EN] = irq_en_reg;
`endif
        end
        ADDR_PERIOD: rdata[CNT_W-1:0] = period_reg;
        ADDR_HIGH:   rdata[CNT_W-1:0] = high_reg;
        ADDR_STATUS: begin
          rdata[STAT_VALID] = valid_reg;
          rdata[STAT_OVF]   = ovf_reg;
          rdata[STAT_BUSY]  = (state_reg == MEASURE);
        end
        default: rdata = '0;
      endcase
    end
  end

  assign apb.prdata = rdata;
  assign apb.pready = 1'b1;

  logic unused_ok;
  assign unused_ok = &{1'b0, apb.pwdata, in_sync};

endmodule

// File: tb/tb_pwm_capture_apb.sv
// Directed bench for pwm_capture_apb; counter width reduced to 10 bits so the all-ones boundary is cheap to reach.
module tb_pwm_capture_apb;
  import pwm_cap_pkg::*;

  localparam int CNT_W = 10;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic pclk;
  logic preset;
  logic pwm_in;
  logic irq;
  logic [15:0] rd;
  logic irq_on;
  int n_cmp;
  int n_err;

  pwm_capture_apb_if apb ();

  pwm_capture_apb #(
    .SYNC_STAGES (2),
    .CNT_W       (CNT_W)
  ) dut (
    .pclk   (pclk),
    .preset (preset),
    .apb    (apb),
    .pwm_in (pwm_in),
    .irq    (irq)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic tick;
    @(posedge pclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
    $display("check %-16s observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic apb_write(input logic [9:0] a, input logic [15:0] d);
    tick;
    apb.psel = 1'b1; apb.pwrite = 1'b1; apb.penable = 1'b0; apb.paddr = a; apb.pwdata = d;
    tick;
    apb.penable = 1'b1;
    tick;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [9:0] a, output logic [15:0] d);
    tick;
    apb.psel = 1'b1; apb.pwrite = 1'b0; apb.penable = 1'b0; apb.paddr = a;
    tick;
    apb.penable = 1'b1;
    #3;
    d = apb.prdata;
    tick;
    apb.psel = 1'b0; apb.penable = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [9:0] a, input logic [15:0] exp);
    logic [15:0] v;
    apb_read(a, v);
    check(tag, v, exp);
  endtask

  // n full periods followed by one more rising edge, so exactly n captures of (p, h).
  task automatic pwm_wave(input int p, input int h, input int n);
    for (int k = 0; k < n; k++) begin
      pwm_in = 1'b1;
      repeat (h) tick;
      pwm_in = 1'b0;
      repeat (p - h) tick;
    end
    pwm_in = 1'b1;
    repeat (h) tick;
    pwm_in = 1'b0;
    repeat (4) tick;
  endtask

  task automatic restart(input logic [15:0] ctrl_val);
    apb_write(ADDR_CTRL, 16'h0);
    apb_write(ADDR_STATUS, 16'h3);
    apb_write(ADDR_CTRL, ctrl_val);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
`ifdef PWMCAP_IRQ_EN
    irq_on = 1'b1;
`else
    irq_on = 1'b0;
`endif
    preset = 1'b0;
    pwm_in = 1'b0;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    apb.paddr = '0; apb.pwdata = '0;
    repeat (3) tick;
    preset = 1'b1;
    tick;

    // Reset state
    check("rst_irq", {15'b0, irq}, 16'h0);
    check("rst_pready", {15'b0, apb.pready}, 16'h1);
    read_check("rst_ctrl", ADDR_CTRL, 16'h0);
    read_check("rst_period", ADDR_PERIOD, 16'h0);
    read_check("rst_high", ADDR_HIGH, 16'h0);
    read_check("rst_status", ADDR_STATUS, 16'h0);

    // Capture something, then reset asynchronously mid-toggle
    apb_write(ADDR_CTRL, 16'h1);
    pwm_wave(10, 3, 2);
    read_check("pre_rst_period", ADDR_PERIOD, 16'd10);
    pwm_in = 1'b1;
    tick;
    pwm_in = 1'b0;
    #2;
    preset = 1'b0;
    #1;
    check("arst_irq", {15'b0, irq}, 16'h0);
    read_check("arst_ctrl", ADDR_CTRL, 16'h0);
    read_check("arst_period", ADDR_PERIOD, 16'h0);
    pwm_in = 1'b1;
    read_check("arst_high", ADDR_HIGH, 16'h0);
    pwm_in = 1'b0;
    read_check("arst_status", ADDR_STATUS, 16'h0);
    tick;
    preset = 1'b1;
    read_check("post_rst_status", ADDR_STATUS, 16'h0);

    // Basic period 10 / high 3
    apb_write(ADDR_CTRL, 16'h1);
    pwm_wave(10, 3, 1);
    read_check("basic_period", ADDR_PERIOD, 16'd10);
    read_check("basic_high", ADDR_HIGH, 16'd3);
    read_check("basic_status", ADDR_STATUS, 16'h5);

    restart(16'h1);
    read_check("restart_status", ADDR_STATUS, 16'h0);
    pwm_wave(10, 3, 4);
    read_check("multi_status", ADDR_STATUS, 16'h5);
    read_check("multi_period", ADDR_PERIOD, 16'd10);
    read_check("multi_high", ADDR_HIGH, 16'd3);

    // Duty sweep
    restart(16'h1);
    pwm_wave(10, 1, 1);
    read_check("duty1_high", ADDR_HIGH, 16'd1);
    read_check("duty1_period", ADDR_PERIOD, 16'd10);
    restart(16'h1);
    pwm_wave(10, 5, 2);
    read_check("duty5_high", ADDR_HIGH, 16'd5);
    restart(16'h1);
    pwm_wave(10, 9, 1);
    read_check("duty9_high", ADDR_HIGH, 16'd9);
    read_check("duty9_period", ADDR_PERIOD, 16'd10);

    // Longest measurable period: counter reaches all-ones exactly as the rise arrives
    restart(16'h1);
    pwm_wave(MAXC, 1, 1);
    read_check("max_period", ADDR_PERIOD, 16'(MAXC));
    read_check("max_high", ADDR_HIGH, 16'd1);
    read_check("max_status", ADDR_STATUS, 16'h5);

    // One cycle longer overflows; re-arms and keeps old results
    restart(16'h1);
    pwm_wave(MAXC + 1, 1, 1);
    read_check("over1_status", ADDR_STATUS, 16'h6);
    read_check("over1_period", ADDR_PERIOD, 16'(MAXC));

    // Overflow from lost signal
    restart(16'h1);
    pwm_wave(10, 3, 1);
    repeat (MAXC + 80) tick;
    read_check("ovf_status", ADDR_STATUS, 16'h3);
    read_check("ovf_period", ADDR_PERIOD, 16'd10);
    read_check("ovf_high", ADDR_HIGH, 16'd3);
    apb_write(ADDR_STATUS, 16'h2);
    read_check("ovf_w1c_status", ADDR_STATUS, 16'h1);
    pwm_wave(10, 4, 1);
    read_check("resume_period", ADDR_PERIOD, 16'd10);
    read_check("resume_high", ADDR_HIGH, 16'd4);

    // Disable write lands on the rise-pulse cycle
    restart(16'h1);
    pwm_wave(10, 3, 1);
    tick;
    pwm_in = 1'b1;
    tick;
    apb.psel = 1'b1; apb.pwrite = 1'b1; apb.penable = 1'b0; apb.paddr = ADDR_CTRL; apb.pwdata = 16'h0;
    tick;
    apb.penable = 1'b1;
    tick;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    pwm_in = 1'b0;
    read_check("race_period", ADDR_PERIOD, 16'd10);
    read_check("race_status", ADDR_STATUS, 16'h1);
    read_check("race_ctrl", ADDR_CTRL, 16'h0);

    // W1C of valid on the cycle valid is set: period 8, high 2
    apb_write(ADDR_STATUS, 16'h3);
    apb_write(ADDR_CTRL, 16'h1);
    tick;
    pwm_in = 1'b1;
    repeat (2) tick;
    pwm_in = 1'b0;
    repeat (6) tick;
    pwm_in = 1'b1;
    tick;
    apb.psel = 1'b1; apb.pwrite = 1'b1; apb.penable = 1'b0; apb.paddr = ADDR_STATUS; apb.pwdata = 16'h1;
    tick;
    apb.penable = 1'b1;
    tick;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    pwm_in = 1'b0;
    read_check("w1c_race_status", ADDR_STATUS, 16'h5);
    read_check("w1c_race_period", ADDR_PERIOD, 16'd8);
    read_check("w1c_race_high", ADDR_HIGH, 16'd2);

    // Read-only and unmapped accesses
    apb_write(ADDR_PERIOD, 16'hAAAA);
    read_check("ro_period", ADDR_PERIOD, 16'd8);
    read_check("unmapped", 10'h3FF, 16'h0);
    check("idle_prdata", apb.prdata, 16'h0);

    // Interrupt
    restart(16'h3);
    read_check("irq_ctrl", ADDR_CTRL, irq_on ? 16'h3 : 16'h1);
    check("irq_idle", {15'b0, irq}, 16'h0);
    tick;
    pwm_in = 1'b1;
    repeat (2) tick;
    pwm_in = 1'b0;
    repeat (6) tick;
    pwm_in = 1'b1;
    repeat (3) tick;
    pwm_in = 1'b0;
    check("irq_valid_cyc", {15'b0, irq}, 16'h0);
    tick;
    check("irq_rise", {15'b0, irq}, {15'b0, irq_on});
    read_check("irq_status", ADDR_STATUS, 16'h5);
    apb_write(ADDR_STATUS, 16'h3);
    check("irq_hold", {15'b0, irq}, {15'b0, irq_on});
    tick;
    check("irq_fall", {15'b0, irq}, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
